// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the multi-cycle CPU controller: default widths,
// opcode values, the FSM state encoding and a small opcode classifier.
// Imported by cpu_alu and cpu_control.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;
   localparam int OPC_W_DEF  = 4;
   localparam int STATE_W    = 3;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_JMP   = 4'h6;
   localparam logic [3:0] OP_JZ    = 4'h7;
   localparam logic [3:0] OP_LDI   = 4'h8;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [STATE_W-1:0] {
      FETCH0 = 3'd0,
      FETCH1 = 3'd1,
      FETCH2 = 3'd2,
      DECODE = 3'd3,
      MEM_RD = 3'd4,
      MEM_WR = 3'd5,
      EXEC   = 3'd6,
      HALT   = 3'd7
   } state_e;

   // Opcodes that read an operand from memory and then finish in EXEC.
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu
// Purely combinational accumulator ALU used in the EXEC state.
// Ports:
//   op_i      opcode of the instruction being executed
//   acc_i     current accumulator
//   mdr_i     operand fetched from memory
//   result_o  LOAD: mdr, ADD: acc+mdr, SUB: acc-mdr, AND: acc&mdr (mod 2^DATA_W)
//   zero_o    result_o == 0
// ---------------------------------------------------------------------------
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OPC_W  = OPC_W_DEF
) (
   input  logic [OPC_W-1:0]  op_i,
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] mdr_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o
);

   always_comb begin
      result_o = mdr_i;
      case (op_i)
         OP_ADD:  result_o = acc_i + mdr_i;
         OP_SUB:  result_o = acc_i - mdr_i;
         OP_AND:  result_o = acc_i & mdr_i;
         default: result_o = mdr_i;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/cpu_control.sv
// ---------------------------------------------------------------------------
// cpu_control
// Multi-cycle fetch/decode/execute controller. Reads the current register
// bank values (*_reg) and produces their next-state values (*_next) every
// cycle; the register bank itself lives outside this block. Also drives the
// single-port memory request/ready handshake.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   PC/IR/ACC/MDR/MAR/zflag _reg   current register values
//   PC/IR/ACC/MDR/MAR/zflag _next  next-state values (hold by default)
//   mem_req, mem_we     request (Moore, from state only) and write enable
//   mem_addr, mem_wdata MAR_reg and MDR_reg
//   mem_rdata, mem_ready read data / completion
//   halted              high in HALT
//   state               FSM state code for debug
//   illegal_op          only when ILLEGAL_TRAP_EN is defined: sticky flag set
//                       when opcodes 9..E trap to HALT
// Configuration macro: ILLEGAL_TRAP_EN (undefined: opcodes 9..E act as NOP).
// ---------------------------------------------------------------------------
module cpu_control
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int OPC_W  = OPC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] PC_reg,
   input  logic [DATA_W-1:0] IR_reg,
   input  logic [DATA_W-1:0] ACC_reg,
   input  logic [DATA_W-1:0] MDR_reg,
   input  logic [ADDR_W-1:0] MAR_reg,
   input  logic              zflag_reg,
   output logic [ADDR_W-1:0] PC_next,
   output logic [DATA_W-1:0] IR_next,
   output logic [DATA_W-1:0] ACC_next,
   output logic [DATA_W-1:0] MDR_next,
   output logic [ADDR_W-1:0] MAR_next,
   output logic              zflag_next,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
`ifdef ILLEGAL_TRAP_EN
   output logic              illegal_op,
`endif
   output logic              halted,
   output logic [2:0]        state
);

   state_e state_q, state_d;

   logic [OPC_W-1:0]  opc;
   logic [ADDR_W-1:0] addr_a;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              unused_ir_bits;

   assign opc    = IR_reg[DATA_W-1 -: OPC_W];
   assign addr_a = IR_reg[ADDR_W-1:0];
   // IR bits between the opcode and the address field carry no meaning.
   assign unused_ir_bits = ^IR_reg[DATA_W-OPC_W-1:ADDR_W];

   assign mem_addr  = MAR_reg;
   assign mem_wdata = MDR_reg;
   assign state     = state_q;

   cpu_alu #(
      .DATA_W (DATA_W),
      .OPC_W  (OPC_W)
   ) u_alu (
      .op_i     (opc),
      .acc_i    (ACC_reg),
      .mdr_i    (MDR_reg),
      .result_o (alu_result),
      .zero_o   (alu_zero)
   );

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   assign illegal_op = illegal_q;

   always_ff @(posedge clk) begin
      if (!rst) illegal_q <= 1'b0;
      else      illegal_q <= illegal_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) state_q <= FETCH0;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      PC_next    = PC_reg;
      IR_next    = IR_reg;
      ACC_next   = ACC_reg;
      MDR_next   = MDR_reg;
      MAR_next   = MAR_reg;
      zflag_next = zflag_reg;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      halted     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_d  = illegal_q;
`endif

      case (state_q)
         FETCH0: begin
            MAR_next = PC_reg;
            state_d  = FETCH1;
         end
         FETCH1: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               MDR_next = mem_rdata;
               state_d  = FETCH2;
            end
         end
         FETCH2: begin
            IR_next = MDR_reg;
            PC_next = PC_reg + ADDR_W'(1);   // natural wrap FF -> 00
            state_d = DECODE;
         end
         DECODE: begin
            state_d = FETCH0;
            if (is_alu_op(opc)) begin
               MAR_next = addr_a;
               state_d  = MEM_RD;
            end else begin
               case (opc)
                  OP_NOP: state_d = FETCH0;
                  OP_STORE: begin
                     MAR_next = addr_a;
                     MDR_next = ACC_reg;
                     state_d  = MEM_WR;
                  end
                  OP_JMP: PC_next = addr_a;
                  OP_JZ: begin
                     if (zflag_reg) PC_next = addr_a;
                  end
                  OP_LDI: begin
                     ACC_next   = {{(DATA_W-ADDR_W){1'b0}}, addr_a};
                     zflag_next = (addr_a == '0);
                  end
                  OP_HALT: state_d = HALT;
                  default: begin
`ifdef ILLEGAL_TRAP_EN
                     illegal_d = 1'b1;
                     state_d   = HALT;
`else
                     state_d   = FETCH0;
`endif
                  end
               endcase
            end
         end
         MEM_RD: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               MDR_next = mem_rdata;
               state_d  = EXEC;
            end
         end
         MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ready) state_d = FETCH0;
         end
         EXEC: begin
            ACC_next   = alu_result;
            zflag_next = alu_zero;
            state_d    = FETCH0;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: state_d = FETCH0;
      endcase

      // Reset overrides everything, including an in-flight transfer.
      if (!rst) begin
         state_d    = FETCH0;
         PC_next    = '0;
         IR_next    = '0;
         ACC_next   = '0;
         MDR_next   = '0;
         MAR_next   = '0;
         zflag_next = 1'b0;
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         halted     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
         illegal_d  = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_control.sv
// ---------------------------------------------------------------------------
// tb_cpu_control
// Directed bench: external register bank and single-port memory model around
// cpu_control, running a small hand-assembled program with hand-computed
// expectations. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_control;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  PC_reg, MAR_reg, PC_next, MAR_next, mem_addr;
   logic [15:0] IR_reg, ACC_reg, MDR_reg, IR_next, ACC_next, MDR_next;
   logic        zflag_reg, zflag_next;
   logic        mem_req, mem_we, mem_ready, halted;
   logic [15:0] mem_wdata, mem_rdata;
   logic [2:0]  state;
`ifdef ILLEGAL_TRAP_EN
   logic        illegal_op;
`endif

   logic [15:0] mem [0:255];
   logic [2:0]  wcnt   = 3'd0;
   logic [2:0]  wait_n = 3'd0;
   int          wr_cnt = 0;
   logic [7:0]  wr_addr = 8'h00;
   logic [15:0] wr_data = 16'h0000;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cpu_control dut (
      .clk        (clk),
      .rst        (rst),
      .PC_reg     (PC_reg),
      .IR_reg     (IR_reg),
      .ACC_reg    (ACC_reg),
      .MDR_reg    (MDR_reg),
      .MAR_reg    (MAR_reg),
      .zflag_reg  (zflag_reg),
      .PC_next    (PC_next),
      .IR_next    (IR_next),
      .ACC_next   (ACC_next),
      .MDR_next   (MDR_next),
      .MAR_next   (MAR_next),
      .zflag_next (zflag_next),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
`ifdef ILLEGAL_TRAP_EN
      .illegal_op (illegal_op),
`endif
      .halted     (halted),
      .state      (state)
   );

   // Register bank
   always @(posedge clk) begin
      PC_reg    <= PC_next;
      IR_reg    <= IR_next;
      ACC_reg   <= ACC_next;
      MDR_reg   <= MDR_next;
      MAR_reg   <= MAR_next;
      zflag_reg <= zflag_next;
   end

   // Memory: ready after wait_n stall cycles of a held request
   assign mem_rdata = mem[mem_addr];
   assign mem_ready = mem_req && (wcnt == wait_n);

   always @(posedge clk) begin
      if (mem_req && !mem_ready) wcnt <= wcnt + 3'd1;
      else                       wcnt <= 3'd0;
      if (mem_req && mem_we && mem_ready) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= mem_addr;
         wr_data <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int         reqs;
      logic [7:0] hold_pc;

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h00] = 16'h8005;  // LDI 5
      mem[8'h01] = 16'h3010;  // ADD [10]
      mem[8'h02] = 16'h7040;  // JZ 40 (taken)
      mem[8'h10] = 16'hFFFB;
      mem[8'h40] = 16'h8007;  // LDI 7
      mem[8'h41] = 16'h7050;  // JZ 50 (not taken)
      mem[8'h42] = 16'h1060;  // LOAD [60]
      mem[8'h43] = 16'h2020;  // STORE [20]
      mem[8'h44] = 16'h4061;  // SUB [61]
      mem[8'h45] = 16'h5062;  // AND [62]
      mem[8'h46] = 16'h5063;  // AND [63]
      mem[8'h47] = 16'h60FF;  // JMP FF
      mem[8'h60] = 16'h1234;
      mem[8'h61] = 16'h1235;
      mem[8'h62] = 16'h00F0;
      mem[8'h63] = 16'h0F00;
      mem[8'hFF] = 16'h0000;  // NOP

      // Reset held for two edges
      rst = 1'b0;
      step(2);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc_next", 32'(PC_next), 32'd0);
      chk("rst_ir_next", 32'(IR_next), 32'd0);
      chk("rst_acc_next", 32'(ACC_next), 32'd0);
      chk("rst_mdr_next", 32'(MDR_next), 32'd0);
      chk("rst_mar_next", 32'(MAR_next), 32'd0);
      chk("rst_z_next", 32'(zflag_next), 32'd0);
      rst = 1'b1;

      // First fetch request
      step(1);
      chk("f1_state", 32'(state), 32'd1);
      chk("f1_req", 32'(mem_req), 32'd1);
      chk("f1_we", 32'(mem_we), 32'd0);
      chk("f1_addr", 32'(mem_addr), 32'h00);

      // LDI 5 completes at edge 4
      step(3);
      chk("ldi_acc", 32'(ACC_reg), 32'h0005);
      chk("ldi_z", 32'(zflag_reg), 32'd0);
      chk("ldi_pc", 32'(PC_reg), 32'h01);
      chk("ldi_state", 32'(state), 32'd0);

      // ADD FFFB: 5 + FFFB wraps to 0, total 10 edges after release
      step(6);
      chk("add_acc", 32'(ACC_reg), 32'h0000);
      chk("add_z", 32'(zflag_reg), 32'd1);
      chk("add_pc", 32'(PC_reg), 32'h02);

      // JZ taken
      step(4);
      chk("jz_taken_pc", 32'(PC_reg), 32'h40);

      // LDI 7 clears zflag
      step(4);
      chk("ldi7_acc", 32'(ACC_reg), 32'h0007);
      chk("ldi7_z", 32'(zflag_reg), 32'd0);

      // JZ not taken
      step(4);
      chk("jz_not_pc", 32'(PC_reg), 32'h42);

      // LOAD 1234
      step(6);
      chk("load_acc", 32'(ACC_reg), 32'h1234);
      chk("load_z", 32'(zflag_reg), 32'd0);

      // STORE with 3 stall cycles per request
      wait_n = 3'd3;
      step(7);
      chk("st_state", 32'(state), 32'd5);
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_addr", 32'(mem_addr), 32'h20);
      chk("st_wdata", 32'(mem_wdata), 32'h1234);
      reqs = 0;
      for (int i = 0; i < 10 && state == 3'd5; i++) begin
         if (mem_req) reqs++;
         step(1);
      end
      chk("st_req_cycles", 32'(reqs), 32'd4);
      chk("st_done_state", 32'(state), 32'd0);
      chk("st_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("st_wr_addr", 32'(wr_addr), 32'h20);
      chk("st_wr_data", 32'(wr_data), 32'h1234);
      wait_n = 3'd0;

      // SUB with borrow, then AND twice
      step(6);
      chk("sub_acc", 32'(ACC_reg), 32'hFFFF);
      chk("sub_z", 32'(zflag_reg), 32'd0);
      step(6);
      chk("and1_acc", 32'(ACC_reg), 32'h00F0);
      step(6);
      chk("and2_acc", 32'(ACC_reg), 32'h0000);
      chk("and2_z", 32'(zflag_reg), 32'd1);

      // JMP FF, NOP at FF wraps PC to 00
      mem[8'h00] = 16'h9000;  // illegal opcode 9
      mem[8'h01] = 16'hF000;  // HALT
      step(4);
      chk("jmp_pc", 32'(PC_reg), 32'hFF);
      step(4);
      chk("wrap_pc", 32'(PC_reg), 32'h00);
      chk("wrap_acc", 32'(ACC_reg), 32'h0000);

      // Opcode 9
      step(4);
`ifdef ILLEGAL_TRAP_EN
      chk("ill_state", 32'(state), 32'd7);
      chk("ill_halted", 32'(halted), 32'd1);
      chk("ill_flag", 32'(illegal_op), 32'd1);
`else
      chk("ill_nop_state", 32'(state), 32'd0);
      chk("ill_nop_pc", 32'(PC_reg), 32'h01);
      chk("ill_nop_halted", 32'(halted), 32'd0);
      step(4);
      chk("halt_state", 32'(state), 32'd7);
      chk("halt_pc", 32'(PC_reg), 32'h02);
`endif

      // HALT holds for 20 cycles with no requests
      hold_pc = PC_reg;
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (mem_req) reqs++;
      end
      chk("halt_reqs", 32'(reqs), 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_pc_hold", 32'(PC_reg), 32'(hold_pc));

      // Reset leaves HALT and restarts fetching at address 0
      rst = 1'b0;
      step(1);
      chk("rst2_state", 32'(state), 32'd0);
      chk("rst2_halted", 32'(halted), 32'd0);
      chk("rst2_req", 32'(mem_req), 32'd0);
`ifdef ILLEGAL_TRAP_EN
      chk("rst2_illegal", 32'(illegal_op), 32'd0);
`endif
      rst = 1'b1;
      step(1);
      chk("restart_req", 32'(mem_req), 32'd1);
      chk("restart_addr", 32'(mem_addr), 32'h00);
      chk("restart_state", 32'(state), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
